// File: rtl/home_status_if.sv
// Controller-to-transmitter bundle: sampled status inputs plus the UART line and frame status.
interface home_status_if;
  logic [2:0] display;
  logic       fdoor;
  logic       rdoor;
  logic       winbuzz;
  logic       alarmbuzz;
  logic       heater;
  logic       cooler;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output display, fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler,
    input  tx, busy, frame_done
  );

  modport slave (
    input  display, fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/home_status_tx.sv
// Sends the controller status as a 2-byte 8N1 UART frame whenever it differs from the last one sent.
// Latency: input change before edge k -> start bit at edge k+1; inputs are ignored while a frame is in flight.
module home_status_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic        Clk,
  input logic        Rst,
  home_status_if.slave hs
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             byte_idx_q, byte_idx_d;
  logic [8:0]       snap, last_sent, hold;
  logic             init_pend;
  logic             load;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             last_tick;
  logic [7:0]       byte0, byte1, cur_byte;

  // The sample register runs through reset so the post-reset frame carries current inputs.
  always_ff @(posedge Clk) begin
    snap <= {hs.display, hs.fdoor, hs.rdoor, hs.winbuzz, hs.alarmbuzz, hs.heater, hs.cooler};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= 1'b0;
      last_sent  <= '0;
      hold       <= '0;
      init_pend  <= 1'b1;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      if (load) begin
        hold      <= snap;
        last_sent <= snap;
        init_pend <= 1'b0;
      end
    end
  end

  // Header bits 10/01 let the panel tell the two bytes apart and resync.
  assign byte0 = {2'b10, hold[5], hold[4], hold[3], hold[8:6]};
  assign byte1 = {5'b01000, hold[2:0]};

  assign last_tick = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    load       = 1'b0;
    done_d     = 1'b0;
    tx_d       = 1'b1;
    cur_byte   = 8'h00;

    case (state_q)
      IDLE: begin
        if ((snap != last_sent) || init_pend) begin
          load       = 1'b1;
          state_d    = START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          byte_idx_d = 1'b0;
        end
      end
      START: begin
        if (last_tick) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          clk_cnt_d  = '0;
          byte_idx_d = ~byte_idx_q;
          if (!byte_idx_q) begin
            state_d = START;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered from the next-state view so tx is glitch-free.
    cur_byte = byte_idx_d ? byte1 : byte0;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_cnt_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign hs.tx         = tx_q;
  assign hs.busy       = (state_q != IDLE);
  assign hs.frame_done = done_q;

endmodule

// File: tb/tb_home_status_tx.sv
// Bench for home_status_tx: directed frame table plus randomized run against a frame-level model.
module tb_home_status_tx;
  localparam int CPB = 4;
  localparam int FLEN = 20 * CPB;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  home_status_if hs();

  home_status_tx #(.CLKS_PER_BIT(CPB)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hs  (hs)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference: which edge the current frame started on and its 20 line bits.
  int         mdl_n = 0;
  bit         m_active = 0;
  int         m_start = 0;
  logic [19:0] m_bits;
  logic [8:0] m_last = '0;
  logic [8:0] m_snap = '0;
  bit         m_init = 1;

  logic last_tx, last_busy, last_done;

  typedef struct {
    logic [8:0] v0;
    int         c1_at;
    logic [8:0] v1;
    int         c2_at;
    logic [8:0] v2;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    int         exp_lat;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, mdl_n);
    end
  endtask

  function automatic logic [19:0] frame_bits(input logic [8:0] v);
    logic [7:0] b0, b1;
    b0 = {2'b10, v[5], v[4], v[3], v[8:6]};
    b1 = {5'b01000, v[2:0]};
    return {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
  endfunction

  // One clock: drive, advance the model by one edge, compare all outputs.
  task automatic step(input logic [8:0] v, input logic r);
    logic etx, ebusy, edone;
    int k;
    {hs.display, hs.fdoor, hs.rdoor, hs.winbuzz, hs.alarmbuzz, hs.heater, hs.cooler} = v;
    Rst = r;
    @(posedge Clk);
    #1;
    mdl_n++;
    etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    if (r) begin
      m_init = 1; m_last = '0; m_active = 0;
    end else if (m_active && mdl_n == m_start + FLEN) begin
      edone = 1'b1; m_active = 0;
    end else if (m_active) begin
      k = (mdl_n - m_start) / CPB;
      etx = m_bits[k]; ebusy = 1'b1;
    end else if (m_snap != m_last || m_init) begin
      m_active = 1; m_start = mdl_n; m_bits = frame_bits(m_snap);
      m_last = m_snap; m_init = 0;
      etx = 1'b0; ebusy = 1'b1;
    end
    m_snap = v;
    last_tx = hs.tx; last_busy = hs.busy; last_done = hs.frame_done;
    chk("tx", 32'(last_tx), 32'(etx));
    chk("busy", 32'(last_busy), 32'(ebusy));
    chk("frame_done", 32'(last_done), 32'(edone));
  endtask

  // Applies one table entry, captures the whole frame off tx and decodes it.
  task automatic run_frame(input int idx);
    logic [8:0] vec;
    logic       samp[FLEN];
    logic [19:0] bv;
    logic [7:0] b0, b1;
    bit started, finished, uniform;
    int lat, k, busy_cnt, done_cnt;
    vec = tv[idx].v0;
    started = 0; finished = 0; uniform = 1;
    lat = 0; k = 0; busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (c == tv[idx].c1_at) vec = tv[idx].v1;
      if (c == tv[idx].c2_at) vec = tv[idx].v2;
      step(vec, 1'b0);
      if (!started && last_tx == 1'b0) begin
        started = 1; lat = c + 1;
      end
      if (started && k < FLEN) begin
        samp[k] = last_tx; k++;
      end
      busy_cnt += int'(last_busy);
      if (last_done) begin
        done_cnt++; finished = 1;
      end
    end
    chk($sformatf("frame%0d_complete", idx), 32'({started, finished}), 32'h3);
    if (tv[idx].exp_lat != 0) chk($sformatf("frame%0d_latency", idx), 32'(lat), 32'(tv[idx].exp_lat));
    for (int b = 0; b < 20; b++) begin
      bv[b] = samp[b*CPB];
      for (int j = 1; j < CPB; j++) if (samp[b*CPB+j] !== samp[b*CPB]) uniform = 0;
    end
    for (int i = 0; i < 8; i++) begin
      b0[i] = bv[1+i];
      b1[i] = bv[11+i];
    end
    chk($sformatf("frame%0d_bit_width", idx), 32'(uniform), 32'd1);
    chk($sformatf("frame%0d_start_stop", idx), 32'({bv[0], bv[9], bv[10], bv[19]}), 32'b0101);
    chk($sformatf("frame%0d_byte0", idx), 32'(b0), 32'(tv[idx].exp_b0));
    chk($sformatf("frame%0d_byte1", idx), 32'(b1), 32'(tv[idx].exp_b1));
    chk($sformatf("frame%0d_busy_cycles", idx), 32'(busy_cnt), 32'(FLEN));
    chk($sformatf("frame%0d_done_pulses", idx), 32'(done_cnt), 32'd1);
  endtask

  task automatic idle_quiet(input string name, input logic [8:0] v, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      step(v, 1'b0);
      if (last_tx == 1'b0 || last_busy) lows++;
    end
    chk(name, 32'(lows), 32'd0);
  endtask

  localparam logic [8:0] V_T2  = 9'b101_001_000;
  localparam logic [8:0] V_T2H = 9'b101_001_010;
  localparam logic [8:0] V_T2C = 9'b101_001_011;
  localparam logic [8:0] V_A   = 9'b010_000_100;
  localparam logic [8:0] V_AF  = 9'b010_100_100;
  localparam logic [8:0] V_B   = 9'b111_110_010;

  initial begin
    logic [8:0] rv, prev;
    logic       rr;
    bit         seen;
    //        v0     c1  v1     c2  v2     b0     b1     lat
    tv[0] = '{9'd0,  -1, 9'd0,  -1, 9'd0,  8'h80, 8'h40, 1};
    tv[1] = '{V_T2,  10, V_T2H, 30, V_T2C, 8'h8D, 8'h40, 2};
    tv[2] = '{V_T2C, -1, V_T2C, -1, V_T2C, 8'h8D, 8'h43, 1};
    tv[3] = '{V_A,   20, V_AF,  40, V_A,   8'h82, 8'h44, 2};
    tv[4] = '{V_B,   -1, V_B,   -1, V_B,   8'hB7, 8'h42, 1};

    // Reset and the forced init frame with all inputs low.
    step(9'd0, 1'b1);
    step(9'd0, 1'b1);
    chk("reset_state", 32'({last_tx, last_busy, last_done}), 32'b100);
    run_frame(0);
    idle_quiet("idle_after_init", 9'd0, 10);

    // Status change, changes while busy, and the single follow-up frame.
    run_frame(1);
    run_frame(2);
    idle_quiet("idle_after_followup", V_T2C, 20);

    // A flag that toggles and reverts mid-frame must not cause another frame.
    run_frame(3);
    idle_quiet("no_frame_after_revert", V_A, 100);

    // Reset during data bit 5 of byte1, then the init frame resends the current inputs.
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step(V_B, 1'b0);
      if (last_tx == 1'b0) seen = 1;
    end
    chk("t5_frame_started", 32'(seen), 32'd1);
    for (int c = 0; c < 65; c++) step(V_B, 1'b0);
    chk("t5_in_frame", 32'(last_busy), 32'd1);
    step(V_B, 1'b1);
    chk("t5_reset_edge", 32'({last_tx, last_busy, last_done}), 32'b100);
    run_frame(4);
    idle_quiet("idle_after_resend", V_B, 10);

    // Randomized run: sparse changes, occasional reverts and rare resets.
    prev = V_B; rv = V_B;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          rv = prev;
        end else begin
          prev = rv;
          rv = 9'($urandom);
        end
      end
      rr = ($urandom_range(0, 699) == 0);
      step(rv, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
